sr_ff_bank: RTL and testbench

Parametrised bank of WIDTH clocked set/reset flip-flops with a common clock, enable and synchronous clear, selectable SR or JK behaviour, and a configurable policy for the S=R=1 condition. Each channel's illegal-input (S=R=1 in SR mode) events are recorded in a sticky per-channel flag and in a saturating event counter. The block replaces free-running cross-coupled latches wherever the design needs registered set/reset state with a defined, observable response to conflicting inputs.

---
 rtl/sr_ff_bank.sv | 107 ++++++++++
 tb/tb_sr_ff_bank.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sr_ff_bank.sv
// sr_ff_bank
// Bank of WIDTH registered set/reset flip-flops sharing one clock, enable
// and synchronous clear. Each channel behaves as an SR flip-flop (MODE=0)
// or a JK flip-flop (MODE=1). In SR mode the S=R=1 condition resolves per
// SR_POLICY and is recorded as a sticky per-channel conflict flag and in a
// saturating count of conflicting cycles.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   en           in   update enable (Q, conflict, conflict_cnt hold when low)
//   sync_clr     in   synchronous load of RESET_VAL into Q, overrides en
//   S, R         in   per-channel set/reset (J/K in MODE 1)
//   conflict_clr in   synchronous clear of conflict and conflict_cnt
//   Q            out  registered state
//   Qbar         out  always ~Q
//   conflict     out  sticky per-channel S=R=1 flag
//   conflict_cnt out  saturating count of cycles with any conflict
module sr_ff_bank #(
  parameter int                 WIDTH         = 8,
  parameter int                 MODE          = 0,
  parameter int                 SR_POLICY     = 0,
  parameter int                 ACTIVE_LOW_IN = 0,
  parameter logic [WIDTH-1:0]   RESET_VAL     = {WIDTH{1'b0}},
  parameter int                 CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             conflict_clr,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_conf;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_r;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_conf_vec;
  logic             w_any_conf;

  assign w_s = (ACTIVE_LOW_IN != 0) ? ~S : S;
  assign w_r = (ACTIVE_LOW_IN != 0) ? ~R : R;

  // Per-channel next state assuming the update is enabled.
  always_comb begin
    w_q_next = r_q;
    for (int i = 0; i < WIDTH; i++) begin
      unique case ({w_s[i], w_r[i]})
        2'b10:   w_q_next[i] = 1'b1;
        2'b01:   w_q_next[i] = 1'b0;
        2'b11: begin
          if (MODE == 1)           w_q_next[i] = ~r_q[i];
          else if (SR_POLICY == 1) w_q_next[i] = 1'b1;
          else if (SR_POLICY == 2) w_q_next[i] = 1'b0;
          else                     w_q_next[i] = r_q[i];
        end
        default: w_q_next[i] = r_q[i];
      endcase
    end
  end

  // A conflict only counts when the flops would actually have updated from
  // S/R in SR mode; a pending sync_clr or a disabled cycle never flags.
  assign w_conf_vec = (MODE == 0 && en && !sync_clr) ? (w_s & w_r) : '0;
  assign w_any_conf = |w_conf_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= RESET_VAL;
      r_conf <= '0;
      r_cnt  <= '0;
    end else begin
      if (sync_clr)
        r_q <= RESET_VAL;
      else if (en)
        r_q <= w_q_next;

      // A clear coinciding with a new event keeps only that event.
      if (conflict_clr) begin
        r_conf <= w_conf_vec;
        r_cnt  <= w_any_conf ? CNT_ONE : '0;
      end else if (w_any_conf) begin
        r_conf <= r_conf | w_conf_vec;
        if (r_cnt != CNT_MAX)
          r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  assign Q            = r_q;
  assign Qbar         = ~r_q;
  assign conflict     = r_conf;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_sr_ff_bank.sv
module tb_sr_ff_bank;

  // Instance index map
  //   0: SR, hold policy,  RESET_VAL A5
  //   1: SR, set-dominant, CNT_W 2
  //   2: SR, reset-dominant, RESET_VAL FF
  //   3: JK
  //   4: SR, hold policy, active-low inputs, RESET_VAL 3C
  logic       clk;
  logic       rst_n;
  logic       en_in [5];
  logic       sc_in [5];
  logic       cc_in [5];
  logic [7:0] s_in  [5];
  logic [7:0] r_in  [5];
  logic [7:0] q_o   [5];
  logic [7:0] qb_o  [5];
  logic [7:0] cf_o  [5];
  logic [7:0] cnt0, cnt2, cnt3, cnt4;
  logic [1:0] cnt1;

  int n_chk;
  int n_pass;

  sr_ff_bank #(.WIDTH(8), .MODE(0), .SR_POLICY(0), .ACTIVE_LOW_IN(0),
               .RESET_VAL(8'hA5), .CNT_W(8)) u_p0 (
    .clk(clk), .rst_n(rst_n), .en(en_in[0]), .sync_clr(sc_in[0]),
    .S(s_in[0]), .R(r_in[0]), .conflict_clr(cc_in[0]),
    .Q(q_o[0]), .Qbar(qb_o[0]), .conflict(cf_o[0]), .conflict_cnt(cnt0));

  sr_ff_bank #(.WIDTH(8), .MODE(0), .SR_POLICY(1), .ACTIVE_LOW_IN(0),
               .RESET_VAL(8'h00), .CNT_W(2)) u_p1 (
    .clk(clk), .rst_n(rst_n), .en(en_in[1]), .sync_clr(sc_in[1]),
    .S(s_in[1]), .R(r_in[1]), .conflict_clr(cc_in[1]),
    .Q(q_o[1]), .Qbar(qb_o[1]), .conflict(cf_o[1]), .conflict_cnt(cnt1));

  sr_ff_bank #(.WIDTH(8), .MODE(0), .SR_POLICY(2), .ACTIVE_LOW_IN(0),
               .RESET_VAL(8'hFF), .CNT_W(8)) u_p2 (
    .clk(clk), .rst_n(rst_n), .en(en_in[2]), .sync_clr(sc_in[2]),
    .S(s_in[2]), .R(r_in[2]), .conflict_clr(cc_in[2]),
    .Q(q_o[2]), .Qbar(qb_o[2]), .conflict(cf_o[2]), .conflict_cnt(cnt2));

  sr_ff_bank #(.WIDTH(8), .MODE(1), .SR_POLICY(0), .ACTIVE_LOW_IN(0),
               .RESET_VAL(8'h00), .CNT_W(8)) u_jk (
    .clk(clk), .rst_n(rst_n), .en(en_in[3]), .sync_clr(sc_in[3]),
    .S(s_in[3]), .R(r_in[3]), .conflict_clr(cc_in[3]),
    .Q(q_o[3]), .Qbar(qb_o[3]), .conflict(cf_o[3]), .conflict_cnt(cnt3));

  sr_ff_bank #(.WIDTH(8), .MODE(0), .SR_POLICY(0), .ACTIVE_LOW_IN(1),
               .RESET_VAL(8'h3C), .CNT_W(8)) u_al (
    .clk(clk), .rst_n(rst_n), .en(en_in[4]), .sync_clr(sc_in[4]),
    .S(s_in[4]), .R(r_in[4]), .conflict_clr(cc_in[4]),
    .Q(q_o[4]), .Qbar(qb_o[4]), .conflict(cf_o[4]), .conflict_cnt(cnt4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drv(input int k, input logic e, input logic sc,
                     input logic [7:0] s, input logic [7:0] r, input logic cc);
    en_in[k] = e;
    sc_in[k] = sc;
    s_in[k]  = s;
    r_in[k]  = r;
    cc_in[k] = cc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b1;
    for (int k = 0; k < 5; k++) drv(k, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drv(4, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0);

    // Asynchronous reset, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_q",      q_o[0],  8'hA5);
    check("rst_qbar",   qb_o[0], 8'h5A);
    check("rst_conf",   cf_o[0], 8'h00);
    check("rst_cnt",    cnt0,    8'h00);
    check("rst_q_p2",   q_o[2],  8'hFF);
    check("rst_q_al",   q_o[4],  8'h3C);
    check("rst_cnt_p1", cnt1,    2'd0);
    tick();
    rst_n = 1'b1;

    // SR basics, hold policy
    drv(0, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0); tick();
    check("sr_zero", q_o[0], 8'h00);
    drv(0, 1'b1, 1'b0, 8'h0F, 8'h00, 1'b0); tick();
    check("sr_set", q_o[0], 8'h0F);
    drv(0, 1'b1, 1'b0, 8'h00, 8'h03, 1'b0); tick();
    check("sr_clr", q_o[0], 8'h0C);
    check("sr_clr_qbar", qb_o[0], 8'hF3);
    drv(0, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0); tick();
    check("sr_en0", q_o[0], 8'h0C);
    check("sr_en0_cnt", cnt0, 8'h00);
    drv(0, 1'b1, 1'b0, 8'h81, 8'h81, 1'b0); tick();
    check("hold_q", q_o[0], 8'h0C);
    check("hold_conf", cf_o[0], 8'h81);
    check("hold_cnt", cnt0, 8'h01);
    drv(0, 1'b0, 1'b0, 8'h81, 8'h81, 1'b0); tick();
    check("en0_nodetect_cnt", cnt0, 8'h01);

    // Set-dominant policy and 2-bit counter saturation
    drv(1, 1'b1, 1'b0, 8'h81, 8'h81, 1'b0);
    tick(); tick(); tick();
    check("setdom_q", q_o[1], 8'h81);
    check("setdom_conf", cf_o[1], 8'h81);
    check("setdom_cnt", cnt1, 2'd3);
    tick(); tick();
    check("sat_cnt", cnt1, 2'd3);
    drv(1, 1'b1, 1'b0, 8'h04, 8'h04, 1'b1); tick();
    check("clr_new_conf", cf_o[1], 8'h04);
    check("clr_new_cnt", cnt1, 2'd1);
    check("clr_new_q", q_o[1], 8'h85);
    drv(1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0); tick();
    check("sticky_conf", cf_o[1], 8'h04);
    drv(1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1); tick();
    check("clr_conf", cf_o[1], 8'h00);
    check("clr_cnt", cnt1, 2'd0);
    check("clr_keeps_q", q_o[1], 8'h85);
    drv(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Reset-dominant policy
    drv(2, 1'b1, 1'b0, 8'h81, 8'h81, 1'b0);
    tick(); tick(); tick();
    check("rstdom_q", q_o[2], 8'h7E);
    check("rstdom_conf", cf_o[2], 8'h81);
    check("rstdom_cnt", cnt2, 8'h03);
    drv(2, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // JK toggle
    drv(3, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0);
    tick(); check("jk_t1", q_o[3], 8'hFF);
    tick(); check("jk_t2", q_o[3], 8'h00);
    tick(); check("jk_t3", q_o[3], 8'hFF);
    check("jk_t3_qbar", qb_o[3], 8'h00);
    tick(); check("jk_t4", q_o[3], 8'h00);
    check("jk_conf", cf_o[3], 8'h00);
    check("jk_cnt", cnt3, 8'h00);
    drv(3, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0); tick();
    check("jk_j", q_o[3], 8'h01);
    drv(3, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0); tick();
    check("jk_k", q_o[3], 8'h00);
    drv(3, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Active-low inputs and sync_clr priority
    drv(4, 1'b1, 1'b0, 8'hFE, 8'hFF, 1'b0); tick();
    check("al_set", q_o[4], 8'h3D);
    check("al_qbar", qb_o[4], 8'hC2);
    drv(4, 1'b1, 1'b0, 8'hFD, 8'hFD, 1'b0); tick();
    check("al_hold_q", q_o[4], 8'h3D);
    check("al_conf", cf_o[4], 8'h02);
    check("al_cnt", cnt4, 8'h01);
    drv(4, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b0); tick();
    check("syncclr_q", q_o[4], 8'h3C);
    check("syncclr_conf", cf_o[4], 8'h02);
    check("syncclr_cnt", cnt4, 8'h01);
    drv(4, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0); tick();
    check("syncclr_noconf_cnt", cnt4, 8'h01);
    check("syncclr_en_q", q_o[4], 8'h3C);
    drv(4, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0);

    // Reset mid-cycle overrides a pending toggle
    drv(3, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_q_p0", q_o[0], 8'hA5);
    check("mid_rst_conf_p0", cf_o[0], 8'h00);
    check("mid_rst_cnt_p2", cnt2, 8'h00);
    tick();
    check("mid_rst_jk_hold", q_o[3], 8'h00);
    rst_n = 1'b1;
    drv(3, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
